// File: rtl/sram_axi_pkg.sv
// Shared AXI3 constants, per-channel state type and write-strobe helper for sram_axi_arbiter.
package sram_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] CACHE_WB = 4'b1111;
    localparam logic [3:0] CACHE_UC = 4'b0000;

    typedef enum logic [1:0] {
        ChIdle,
        ChRdWait,
        ChWrWait
    } ch_state_t;

    // Byte-lane strobe for a 32-bit bus from transfer size and low address bits.
    function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr;
            SIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
            SIZE_WORD: strb = 4'b1111;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_axi_arbiter_rr_arbiter.sv
// Request vector to one-hot grant. Round-robin by default; with SRAM_AXI_STRICT_PRIO_EN defined
// it becomes fixed priority (lowest index wins) and the pointer register disappears.
module rr_arbiter
    import sram_axi_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

`ifdef SRAM_AXI_STRICT_PRIO_EN
    logic unused_strict;
    assign unused_strict = clk_i ^ rst_ni ^ advance_i;

    // Isolate the lowest set request bit.
    always_comb begin
        gnt_o = req_i & (~req_i + N'(1));
    end
`else
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] gnt_idx;
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;

    // Scan requests starting at the pointer, wrapping modulo N; first hit wins.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PtrW + 1)'(i);
            if (sum >= (PtrW + 1)'(N)) begin
                sum = sum - (PtrW + 1)'(N);
            end
            idx = sum[PtrW-1:0];
            if (req_i[idx] && (gnt_o == '0)) begin
                gnt_o[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // Pointer moves just past the channel that was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (|req_i)) begin
            ptr_d = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/sram_axi_arbiter.sv
// NUM_CH SRAM-like request ports bridged onto one AXI3 master, single-beat, one outstanding
// transaction per channel, AXI ID = channel index. Define SRAM_AXI_STRICT_PRIO_EN for fixed
// priority arbitration instead of round-robin.
module sram_axi_arbiter
    import sram_axi_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [2*NUM_CH-1:0]      ch_size,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
    input  logic [NUM_CH-1:0]        ch_uncached,
    output logic [NUM_CH-1:0]        ch_addr_ok,
    output logic [NUM_CH-1:0]        ch_data_ok,
    output logic [DATA_W*NUM_CH-1:0] ch_rdata,
    output logic [ID_W-1:0]          arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [3:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_W-1:0]          rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [ID_W-1:0]          awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [ID_W-1:0]          wid,
    output logic [DATA_W-1:0]        wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [ID_W-1:0]          bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    ch_state_t state_q [NUM_CH];
    ch_state_t state_d [NUM_CH];

    logic [NUM_CH-1:0] ch_idle, rd_elig, wr_elig, rd_gnt, wr_gnt;
    logic              rd_can, wr_can;
    logic [ID_W-1:0]   rd_idx, wr_idx;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [1:0]        rd_size, wr_size;
    logic              rd_uc, wr_uc;
    logic [DATA_W-1:0] wr_data;

    logic              ar_v_q, ar_v_d, ar_uc_q, ar_uc_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [1:0]        ar_size_q, ar_size_d;
    logic              aw_v_q, aw_v_d, w_v_q, w_v_d, aw_uc_q, aw_uc_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [1:0]        aw_size_q, aw_size_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;

    logic unused_resp;
    assign unused_resp = ^{rresp, rlast, bresp};

    // A holding slot can take a new request if empty or emptying this cycle.
    assign rd_can  = ~ar_v_q | arready;
    assign wr_can  = (~aw_v_q | awready) & (~w_v_q | wready);
    assign rd_elig = ch_req & ~ch_wr & ch_idle & {NUM_CH{rd_can}};
    assign wr_elig = ch_req & ch_wr & ch_idle & {NUM_CH{wr_can}};

    rr_arbiter #(.N(NUM_CH)) u_rd_arb (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .req_i     (rd_elig),
        .advance_i (rd_can),
        .gnt_o     (rd_gnt)
    );

    rr_arbiter #(.N(NUM_CH)) u_wr_arb (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .req_i     (wr_elig),
        .advance_i (wr_can),
        .gnt_o     (wr_gnt)
    );

    // Per-channel status, granted-request field muxes and response matching.
    always_comb begin
        rd_idx   = '0;
        wr_idx   = '0;
        rd_addr  = '0;
        wr_addr  = '0;
        rd_size  = '0;
        wr_size  = '0;
        rd_uc    = 1'b0;
        wr_uc    = 1'b0;
        wr_data  = '0;
        ch_idle  = '0;
        ch_data_ok = '0;
        ch_rdata = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            ch_idle[k] = (state_q[k] == ChIdle);
            ch_rdata[k*DATA_W +: DATA_W] = rdata;
            ch_data_ok[k] = (rvalid && (rid == ID_W'(k)) && (state_q[k] == ChRdWait)) ||
                            (bvalid && (bid == ID_W'(k)) && (state_q[k] == ChWrWait));
            if (rd_gnt[k]) begin
                rd_idx  = ID_W'(k);
                rd_addr = ch_addr[k*ADDR_W +: ADDR_W];
                rd_size = ch_size[2*k +: 2];
                rd_uc   = ch_uncached[k];
            end
            if (wr_gnt[k]) begin
                wr_idx  = ID_W'(k);
                wr_addr = ch_addr[k*ADDR_W +: ADDR_W];
                wr_size = ch_size[2*k +: 2];
                wr_uc   = ch_uncached[k];
                wr_data = ch_wdata[k*DATA_W +: DATA_W];
            end
        end
        ch_addr_ok = rd_gnt | wr_gnt;
    end

    // Channel FSMs: a response releases the channel, a grant parks it in the matching wait.
    always_comb begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
            state_d[k] = state_q[k];
            if (ch_data_ok[k]) begin
                state_d[k] = ChIdle;
            end else if (rd_gnt[k]) begin
                state_d[k] = ChRdWait;
            end else if (wr_gnt[k]) begin
                state_d[k] = ChWrWait;
            end
        end
    end

    // AR/AW/W holding registers: clear on handshake, reload on grant.
    always_comb begin
        ar_v_d    = ar_v_q;
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        ar_size_d = ar_size_q;
        ar_uc_d   = ar_uc_q;
        aw_v_d    = aw_v_q;
        w_v_d     = w_v_q;
        aw_id_d   = aw_id_q;
        aw_addr_d = aw_addr_q;
        aw_size_d = aw_size_q;
        aw_uc_d   = aw_uc_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (ar_v_q && arready) ar_v_d = 1'b0;
        if (aw_v_q && awready) aw_v_d = 1'b0;
        if (w_v_q && wready)   w_v_d  = 1'b0;
        if (|rd_gnt) begin
            ar_v_d    = 1'b1;
            ar_id_d   = rd_idx;
            ar_addr_d = rd_addr;
            ar_size_d = rd_size;
            ar_uc_d   = rd_uc;
        end
        if (|wr_gnt) begin
            aw_v_d    = 1'b1;
            w_v_d     = 1'b1;
            aw_id_d   = wr_idx;
            aw_addr_d = wr_addr;
            aw_size_d = wr_size;
            aw_uc_d   = wr_uc;
            w_data_d  = wr_data;
            w_strb_d  = gen_wstrb(wr_size, wr_addr[1:0]);
        end
    end

    // State registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < int'(NUM_CH); k++) state_q[k] <= ChIdle;
            ar_v_q    <= 1'b0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            ar_uc_q   <= 1'b0;
            aw_v_q    <= 1'b0;
            w_v_q     <= 1'b0;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            aw_uc_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++) state_q[k] <= state_d[k];
            ar_v_q    <= ar_v_d;
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            ar_size_q <= ar_size_d;
            ar_uc_q   <= ar_uc_d;
            aw_v_q    <= aw_v_d;
            w_v_q     <= w_v_d;
            aw_id_q   <= aw_id_d;
            aw_addr_q <= aw_addr_d;
            aw_size_q <= aw_size_d;
            aw_uc_q   <= aw_uc_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, ar_size_q};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = ar_uc_q ? CACHE_UC : CACHE_WB;
    assign arprot  = 3'b000;
    assign arvalid = ar_v_q;
    assign rready  = 1'b1;

    assign awid    = aw_id_q;
    assign awaddr  = aw_addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, aw_size_q};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = aw_uc_q ? CACHE_UC : CACHE_WB;
    assign awprot  = 3'b000;
    assign awvalid = aw_v_q;

    assign wid     = aw_id_q;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wlast   = 1'b1;
    assign wvalid  = w_v_q;
    assign bready  = 1'b1;

endmodule
